// File: rtl/urv_tb_mem.sv
// urv_tb_mem -- behavioural memory, console and stall generator for a uRV test bench.
//
// Purpose:
//   Word-organised memory (2**g_addr_bits x 32 bit) with two ports:
//   - an instruction port that returns one word per cycle. Stalls come from a
//     16-bit LFSR: when lfsr[7:0] is below g_im_stall_thr, the port stalls.
//   - a data port run by an IDLE -> WAIT -> DONE handshake. The data port has
//     g_dm_latency wait cycles and a one-cycle done pulse.
//   A store to g_console_addr pushes a byte into a console FIFO and leaves
//   memory untouched. A load from g_console_addr returns the FIFO status.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   im_addr_i             fetch byte address
//   im_data_o/im_valid_o  registered fetch word and its valid flag
//   dm_addr_i             data byte address
//   dm_data_s_i           store data
//   dm_data_select_i      byte selects
//   dm_store_i/dm_load_i  request strobes (store wins when both are high)
//   dm_data_l_o           load data, held until the next load completes
//   dm_ready_o            high while a request can be accepted
//   dm_load_done_o        one-cycle completion pulse for a load
//   dm_store_done_o       one-cycle completion pulse for a store
//   cons_data_o           console FIFO head
//   cons_valid_o          console FIFO holds data
//   cons_ready_i          consumer pops the head
//   cons_overflow_o       sticky flag: a console byte was dropped
module urv_tb_mem #(
    parameter int          g_addr_bits    = 14,
    parameter int          g_im_stall_thr = 0,
    parameter int          g_dm_latency   = 0,
    parameter logic [31:0] g_console_addr = 32'h0010_0000,
    parameter int          g_cons_depth   = 16,
    parameter logic [15:0] g_seed         = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_ready_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [7:0]  cons_data_o,
    output logic        cons_valid_o,
    input  logic        cons_ready_i,
    output logic        cons_overflow_o
);

    localparam int          DEPTH     = 1 << g_addr_bits;
    localparam int          PW        = $clog2(g_cons_depth);
    localparam logic [7:0]  STALL_THR = 8'(g_im_stall_thr);
    localparam logic [3:0]  LATENCY   = 4'(g_dm_latency);
    localparam logic [15:0] SEED      = (g_seed == 16'h0000) ? 16'hACE1 : g_seed;
    localparam logic [PW:0] FULL_CNT  = (PW + 1)'(g_cons_depth);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [31:0] mem  [DEPTH];
    logic [7:0]  fifo [g_cons_depth];

    // instruction side
    logic [g_addr_bits-1:0] im_idx;
    logic                   unused_im_bits;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [8:0]             thr_diff;
    logic [31:0]            im_data_q, im_data_d;
    logic                   im_valid_q, im_valid_d;

    // data side
    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [g_addr_bits-1:0] idx_q, idx_d;
    logic                   cons_q, cons_d;
    logic                   store_q, store_d;
    logic                   ready_q, ready_d;
    logic                   ld_done_q, ld_done_d;
    logic                   st_done_q, st_done_d;
    logic [31:0]            data_l_q, data_l_d;
    logic [g_addr_bits-1:0] dm_idx;
    logic                   cons_hit;
    logic                   accept;
    logic                   mem_we;

    // console FIFO
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_empty, fifo_full;
    logic                   pop, push_req, push_ok;

    assign im_idx         = im_addr_i[g_addr_bits+1:2];
    assign unused_im_bits = ^{im_addr_i[31:g_addr_bits+2], im_addr_i[1:0]};
    assign dm_idx         = dm_addr_i[g_addr_bits+1:2];
    assign cons_hit       = (dm_addr_i == g_console_addr);

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1. The stall test uses the
    // borrow of a 9-bit subtraction so that a zero threshold does not turn
    // into a constant comparison.
    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        thr_diff   = {1'b0, lfsr_q[7:0]} - {1'b0, STALL_THR};
        im_valid_d = ~thr_diff[8];
        im_data_d  = im_valid_d ? mem[im_idx] : im_data_q;
    end

    // Data-port FSM. Load data is fetched on the edge that enters DONE.
    // dm_data_l_o is therefore valid together with dm_load_done_o.
    // With zero latency, that edge is the accept edge, so idx_d still comes
    // from the live address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cons_d  = cons_q;
        store_d = store_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && (dm_load_i || dm_store_i)) begin
                    accept  = 1'b1;
                    idx_d   = dm_idx;
                    cons_d  = cons_hit;
                    store_d = dm_store_i;
                    if (LATENCY == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LATENCY - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d   = (state_d == ST_IDLE);
        ld_done_d = (state_d == ST_DONE) && !store_d;
        st_done_d = (state_d == ST_DONE) && store_d;
        data_l_d  = data_l_q;
        if (ld_done_d) begin
            data_l_d = cons_d ? {30'b0, fifo_full, fifo_empty} : mem[idx_d];
        end
    end

    // Stores commit at the accept edge. Console stores never touch memory.
    assign mem_we     = accept & dm_store_i & ~cons_hit;
    assign push_req   = accept & dm_store_i & cons_hit & dm_data_select_i[0];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = ~fifo_empty & cons_ready_i;
    // A full FIFO still takes the byte when the head leaves on the same edge.
    assign push_ok    = push_req & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push_req & fifo_full & ~pop);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q     <= SEED;
            im_data_q  <= '0;
            im_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cons_q     <= 1'b0;
            store_q    <= 1'b0;
            ready_q    <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            data_l_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            im_data_q  <= im_data_d;
            im_valid_q <= im_valid_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cons_q     <= cons_d;
            store_q    <= store_d;
            ready_q    <= ready_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
            data_l_q   <= data_l_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset; the bench preloads it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_data_select_i[b]) begin
                    mem[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
                end
            end
        end
        if (push_ok) begin
            fifo[wr_ptr_q] <= dm_data_s_i[7:0];
        end
    end

    assign im_data_o       = im_data_q;
    assign im_valid_o      = im_valid_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_ready_o      = ready_q;
    assign dm_load_done_o  = ld_done_q;
    assign dm_store_done_o = st_done_q;
    assign cons_valid_o    = ~fifo_empty;
    assign cons_data_o     = fifo_empty ? 8'h00 : fifo[rd_ptr_q];
    assign cons_overflow_o = ovf_q;

endmodule
